// File: rtl/reduce_accum.sv
// Group-sum adder tree plus K-fold accumulator downstream of the multiplier array.
// Define REDUCE_ACCUM_SAT_EN to make the fold accumulation saturate instead of wrap.

module reduce_accum_grp #(
  parameter int OUT_W = 24,
  parameter int GROUP = 8,
  parameter int ACC_W = 32,
  parameter int LOG2G = 3
) (
  input  logic                   CLK,
  input  logic                   rst,
  input  logic [LOG2G:0]         i_vin,
  input  logic [GROUP*OUT_W-1:0] i_lanes,
  input  logic                   i_tv,
  input  logic                   i_accum,
  input  logic                   i_emit,
  output logic [ACC_W-1:0]       o_data
);
  // All tree levels share one node vector: level k starts at 2*(GROUP - (GROUP>>k)).
  localparam int NODES = 2*GROUP - 1;

  logic [NODES-1:0][ACC_W-1:0] r_node;
  logic [GROUP-1:0][ACC_W-1:0] w_ext;
  logic [ACC_W-1:0]            r_acc, w_sum, w_add, w_acc_nxt;

  for (genvar j = 0; j < GROUP; j++) begin : g_ext
    assign w_ext[j] = {{(ACC_W-OUT_W){i_lanes[j*OUT_W+OUT_W-1]}}, i_lanes[j*OUT_W +: OUT_W]};
  end

  always_ff @(posedge CLK or negedge rst)
    if (!rst)          r_node[GROUP-1:0] <= '0;
    else if (i_vin[0]) r_node[GROUP-1:0] <= w_ext;

  for (genvar k = 1; k <= LOG2G; k++) begin : g_lvl
    for (genvar j = 0; j < (GROUP >> k); j++) begin : g_node
      localparam int D = 2*(GROUP - (GROUP >> k)) + j;
      localparam int S = 2*(GROUP - (GROUP >> (k-1))) + 2*j;
      always_ff @(posedge CLK or negedge rst)
        if (!rst)          r_node[D] <= '0;
        else if (i_vin[k]) r_node[D] <= r_node[S] + r_node[S+1];
    end
  end

  assign w_sum = r_node[NODES-1];

`ifdef REDUCE_ACCUM_SAT_EN
  logic [ACC_W:0] w_wide;
  assign w_wide = {r_acc[ACC_W-1], r_acc} + {w_sum[ACC_W-1], w_sum};
  // Extra sign bit disagreeing with the MSB means the add left the signed range.
  assign w_add  = (w_wide[ACC_W] == w_wide[ACC_W-1]) ? w_wide[ACC_W-1:0] :
                  w_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`else
  assign w_add  = r_acc + w_sum;
`endif

  assign w_acc_nxt = i_accum ? w_add : w_sum;

  always_ff @(posedge CLK or negedge rst)
    if (!rst) begin
      r_acc  <= '0;
      o_data <= '0;
    end else begin
      if (i_tv)   r_acc  <= w_acc_nxt;
      if (i_emit) o_data <= w_acc_nxt;
    end
endmodule

module reduce_accum #(
  parameter int OUT_DATA_TYPE = 24,
  parameter int NUM_PES       = 64,
  parameter int GROUP         = 8,
  parameter int ACC_DATA_TYPE = 32,
  parameter int FOLD_W        = 8
) (
  input  logic                                        CLK,
  input  logic                                        rst,
  input  logic                                        i_valid,
  input  logic [NUM_PES*OUT_DATA_TYPE-1:0]            i_data_bus,
  input  logic [FOLD_W-1:0]                           i_num_folds,
  output logic                                        o_valid,
  output logic [(NUM_PES/GROUP)*ACC_DATA_TYPE-1:0]    o_data_bus,
  output logic                                        o_busy
);
  localparam int LOG2G = $clog2(GROUP);
  localparam int NGRP  = NUM_PES / GROUP;

  typedef enum logic {S_IDLE, S_ACCUM} state_t;

  logic [LOG2G:0]             r_vld_pipe;
  logic [LOG2G:0][FOLD_W-1:0] r_nf_pipe;
  logic [LOG2G:0]             w_vin;
  logic                       w_tv, w_emit, w_accum;
  logic [FOLD_W-1:0]          w_nf, r_fold_cnt, w_cnt_nxt, r_target, w_tgt_nxt;
  state_t                     r_state, w_state_nxt;

  // Fold count rides the tree beside the beat so it lines up with its group sum.
  always_ff @(posedge CLK or negedge rst)
    if (!rst) begin
      r_vld_pipe <= '0;
      r_nf_pipe  <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[LOG2G-1:0], i_valid};
      if (i_valid) r_nf_pipe[0] <= i_num_folds;
      for (int k = 1; k <= LOG2G; k++)
        if (r_vld_pipe[k-1]) r_nf_pipe[k] <= r_nf_pipe[k-1];
    end

  assign w_vin = {r_vld_pipe[LOG2G-1:0], i_valid};
  assign w_tv  = r_vld_pipe[LOG2G];
  assign w_nf  = (r_nf_pipe[LOG2G] == '0) ? FOLD_W'(1) : r_nf_pipe[LOG2G];

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_fold_cnt;
    w_tgt_nxt   = r_target;
    w_emit      = 1'b0;
    w_accum     = (r_state == S_ACCUM);
    case (r_state)
      S_IDLE: if (w_tv) begin
        w_tgt_nxt = w_nf;
        w_cnt_nxt = FOLD_W'(1);
        if (w_nf == FOLD_W'(1)) w_emit = 1'b1;
        else                    w_state_nxt = S_ACCUM;
      end
      S_ACCUM: if (w_tv) begin
        w_cnt_nxt = r_fold_cnt + FOLD_W'(1);
        if (w_cnt_nxt == r_target) begin
          w_emit      = 1'b1;
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge rst)
    if (!rst) begin
      r_state    <= S_IDLE;
      r_fold_cnt <= '0;
      r_target   <= '0;
      o_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_fold_cnt <= w_cnt_nxt;
      r_target   <= w_tgt_nxt;
      o_valid    <= w_emit;
    end

  assign o_busy = (r_state == S_ACCUM) | (|r_vld_pipe);

  for (genvar g = 0; g < NGRP; g++) begin : g_grp
    reduce_accum_grp #(
      .OUT_W(OUT_DATA_TYPE), .GROUP(GROUP), .ACC_W(ACC_DATA_TYPE), .LOG2G(LOG2G)
    ) u_grp (
      .CLK     (CLK),
      .rst     (rst),
      .i_vin   (w_vin),
      .i_lanes (i_data_bus[g*GROUP*OUT_DATA_TYPE +: GROUP*OUT_DATA_TYPE]),
      .i_tv    (w_tv),
      .i_accum (w_accum),
      .i_emit  (w_emit),
      .o_data  (o_data_bus[g*ACC_DATA_TYPE +: ACC_DATA_TYPE])
    );
  end
endmodule

// File: tb/tb_reduce_accum.sv
// Bench for reduce_accum: a 32-bit and a 28-bit accumulator instance share stimulus and are
// compared every cycle against a sequence-level model (group sums, fold targets, emit timing).
module tb_reduce_accum;
  localparam int OW = 24, NP = 64, G = 8, NG = 8, FW = 8, MAXC = 1024, LAT = 4;
`ifdef REDUCE_ACCUM_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic               CLK, rst, i_valid;
  logic [NP*OW-1:0]   i_data_bus;
  logic [FW-1:0]      i_num_folds;
  logic               o_valid32, o_busy32, o_valid28, o_busy28;
  logic [NG*32-1:0]   o_data32;
  logic [NG*28-1:0]   o_data28;

  reduce_accum #(.OUT_DATA_TYPE(OW), .NUM_PES(NP), .GROUP(G), .ACC_DATA_TYPE(32), .FOLD_W(FW)) u_dut32 (
    .CLK(CLK), .rst(rst), .i_valid(i_valid), .i_data_bus(i_data_bus), .i_num_folds(i_num_folds),
    .o_valid(o_valid32), .o_data_bus(o_data32), .o_busy(o_busy32));

  reduce_accum #(.OUT_DATA_TYPE(OW), .NUM_PES(NP), .GROUP(G), .ACC_DATA_TYPE(28), .FOLD_W(FW)) u_dut28 (
    .CLK(CLK), .rst(rst), .i_valid(i_valid), .i_data_bus(i_data_bus), .i_num_folds(i_num_folds),
    .o_valid(o_valid28), .o_data_bus(o_data28), .o_busy(o_busy28));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int          tests = 0, fails = 0, cyc = 0;
  int          lanes [NP];
  bit          ev [MAXC];
  bit          bm [MAXC];
  logic [255:0] ed32 [MAXC];
  logic [223:0] ed28 [MAXC];
  logic [255:0] last32;
  logic [223:0] last28;
  bit          in_seq;
  int          seq_first, seq_tgt, seq_cnt;
  longint      acc32 [NG];
  longint      acc28 [NG];

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    assert (act === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, act, exp);
    end
  endtask

  function automatic longint wrapw(input longint v, input int w);
    longint m;
    m = v & ((64'sd1 <<< w) - 1);
    if (m >= (64'sd1 <<< (w-1))) m -= (64'sd1 <<< w);
    return m;
  endfunction

  function automatic longint fold(input longint a, input longint s, input int w);
    longint r, mx, mn;
    r  = a + s;
    mx = (64'sd1 <<< (w-1)) - 1;
    mn = -(64'sd1 <<< (w-1));
    if (SAT) return (r > mx) ? mx : (r < mn) ? mn : r;
    return wrapw(r, w);
  endfunction

  // A beat accepted at edge e: result is due at e+LAT; tree stays busy for LAT edges.
  task automatic model_beat(input int e, input int nf);
    longint gs;
    for (int i = e; i < e + LAT && i < MAXC; i++) bm[i] = 1'b1;
    if (!in_seq) begin
      in_seq = 1'b1; seq_first = e; seq_tgt = (nf == 0) ? 1 : nf; seq_cnt = 0;
    end
    for (int g = 0; g < NG; g++) begin
      gs = 0;
      for (int j = 0; j < G; j++) gs += lanes[g*G + j];
      if (seq_cnt == 0) begin
        acc32[g] = wrapw(gs, 32); acc28[g] = wrapw(gs, 28);
      end else begin
        acc32[g] = fold(acc32[g], gs, 32); acc28[g] = fold(acc28[g], gs, 28);
      end
    end
    seq_cnt++;
    if (seq_cnt == seq_tgt) begin
      if (e + LAT < MAXC) begin
        ev[e+LAT] = 1'b1;
        for (int g = 0; g < NG; g++) begin
          ed32[e+LAT][g*32 +: 32] = acc32[g][31:0];
          ed28[e+LAT][g*28 +: 28] = acc28[g][27:0];
        end
      end
      for (int i = seq_first + LAT; i < e + LAT && i < MAXC; i++) bm[i] = 1'b1;
      in_seq = 1'b0;
    end
  endtask

  task automatic check(input int e);
    logic eb;
    if (ev[e]) begin last32 = ed32[e]; last28 = ed28[e]; end
    eb = bm[e] || (in_seq && e >= seq_first + LAT);
    chk($sformatf("valid32@%0d", e), {255'd0, o_valid32}, {255'd0, ev[e]});
    chk($sformatf("valid28@%0d", e), {255'd0, o_valid28}, {255'd0, ev[e]});
    chk($sformatf("data32@%0d", e),  o_data32, last32);
    chk($sformatf("data28@%0d", e),  {32'd0, o_data28}, {32'd0, last28});
    chk($sformatf("busy32@%0d", e),  {255'd0, o_busy32}, {255'd0, eb});
    chk($sformatf("busy28@%0d", e),  {255'd0, o_busy28}, {255'd0, eb});
  endtask

  task automatic tick(input bit v, input int nf);
    i_valid = v;
    i_num_folds = nf[FW-1:0];
    for (int i = 0; i < NP; i++) i_data_bus[i*OW +: OW] = lanes[i][OW-1:0];
    if (v && rst) model_beat(cyc + 1, nf);
    @(posedge CLK); cyc++;
    @(negedge CLK);
    check(cyc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 0);
  endtask

  task automatic set_all(input int v);
    for (int i = 0; i < NP; i++) lanes[i] = v;
  endtask

  task automatic set_rand();
    for (int i = 0; i < NP; i++) lanes[i] = int'($urandom_range(0, (1 << OW) - 1)) - (1 << (OW-1));
  endtask

  task automatic do_reset();
    rst = 1'b0; i_valid = 1'b0;
    #1;
    chk("rst_async_valid32", {255'd0, o_valid32}, 256'd0);
    chk("rst_async_data32",  o_data32, 256'd0);
    chk("rst_async_busy32",  {255'd0, o_busy32}, 256'd0);
    chk("rst_async_data28",  {32'd0, o_data28}, 256'd0);
    for (int i = cyc + 1; i < MAXC; i++) begin ev[i] = 1'b0; bm[i] = 1'b0; end
    in_seq = 1'b0; last32 = '0; last28 = '0;
    @(posedge CLK); cyc++;
    @(negedge CLK);
    check(cyc);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; i_valid = 1'b0; i_data_bus = '0; i_num_folds = '0;
    last32 = '0; last28 = '0; in_seq = 1'b0;
    for (int i = 0; i < MAXC; i++) begin ev[i] = 1'b0; bm[i] = 1'b0; ed32[i] = '0; ed28[i] = '0; end
    set_all(0);
    @(posedge CLK); cyc++;
    @(negedge CLK);
    check(cyc);
    rst = 1'b1;
    idle(2);

    // N=1, all ones: each group sums to 8.
    set_all(1); tick(1'b1, 1); idle(5);
    chk("n1_ones_grp0", {224'd0, o_data32[31:0]}, 256'd8);

    // N=3 with gaps: 8*(2-1+5) = 48.
    set_all(2);  tick(1'b1, 3); idle(2);
    set_all(-1); tick(1'b1, 3); idle(2);
    set_all(5);  tick(1'b1, 3); idle(5);
    chk("n3_gap_grp7", {224'd0, o_data32[7*32 +: 32]}, 256'd48);

    // Back-to-back N=1 beats.
    set_all(1); tick(1'b1, 1);
    set_all(2); tick(1'b1, 1);
    set_all(3); tick(1'b1, 1);
    idle(5);

    // Fold count changed mid-sequence is ignored; zero behaves as one.
    set_rand(); tick(1'b1, 2);
    set_rand(); tick(1'b1, 5);
    set_rand(); tick(1'b1, 0);
    idle(5);

    // Overflow on the 28-bit instance: 8 beats of 8*(2^23-1).
    set_all((1 << 23) - 1);
    for (int i = 0; i < 8; i++) tick(1'b1, 8);
    idle(5);
    chk("ovf_grp0_w28", {228'd0, o_data28[27:0]}, SAT ? 256'h7FFFFFF : 256'hFFFFFC0);
    chk("ovf_grp0_w32", {224'd0, o_data32[31:0]}, 256'h1FFFFFC0);

    // Reset mid-sequence, then a fresh N=1 beat.
    set_rand(); tick(1'b1, 4);
    set_rand(); tick(1'b1, 4);
    idle(1);
    do_reset();
    set_rand(); tick(1'b1, 1); idle(5);

    // Sequence A's last beat adjacent to sequence B's first.
    set_rand(); tick(1'b1, 2);
    set_rand(); tick(1'b1, 2);
    set_rand(); tick(1'b1, 3);
    set_rand(); tick(1'b1, 3);
    set_rand(); tick(1'b1, 3);
    idle(6);

    // Random beats, gaps and fold counts.
    for (int n = 0; n < 400; n++) begin
      set_rand();
      tick($urandom_range(0, 9) < 6, int'($urandom_range(0, 6)));
    end
    idle(8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/reduce_accum.md
# reduce_accum

Pipelined reduction and fold-accumulation stage directly downstream of the multiplier-switch array. Each cycle it takes the full product bus, sums fixed-size lane groups through a registered binary adder tree, then accumulates those group sums over a programmable number of beats (K-folds). It emits one result vector per completed fold sequence to the output collection logic.

## Interface
- OUT_DATA_TYPE, 24, width of each incoming product lane (signed)
- NUM_PES, 64, number of product lanes on the input bus
- GROUP, 8, lanes summed per group; power of two, 2..NUM_PES, divides NUM_PES
- ACC_DATA_TYPE, 32, width of each accumulated result (signed), >= OUT_DATA_TYPE + log2(GROUP)
- FOLD_W, 8, width of fold-count input
- CLK  input  1  clock, all state on rising edge
- rst  input  1  asynchronous active-low reset
- i_valid  input  1  product beat valid
- i_data_bus  input  NUM_PES*OUT_DATA_TYPE  products; lane i at [i*OUT_DATA_TYPE +: OUT_DATA_TYPE]
- i_num_folds  input  FOLD_W  beats per output; sampled on first beat of each fold sequence
- o_valid  output  1  one-cycle pulse, result vector valid
- o_data_bus  output  (NUM_PES/GROUP)*ACC_DATA_TYPE  group g result at [g*ACC_DATA_TYPE +: ACC_DATA_TYPE]
- o_busy  output  1  fold sequence in progress or beats in tree

## Operation
- Lanes sign-extended to ACC_DATA_TYPE at tree input; all adds signed, wrap modulo 2^ACC_DATA_TYPE (default build).
- Tree: LOG2G = log2(GROUP) registered levels; level k holds GROUP>>k partial sums per group. A valid bit travels alongside each level; data registers at a level load only when that level's valid-in is 1.
- Accumulator FSM, states IDLE and ACCUM:
  - IDLE: on tree-output valid, latch fold target N = i_num_folds value captured with that beat (0 treated as 1); acc = group sum; fold_cnt = 1; if N == 1 emit, stay IDLE, else go ACCUM.
  - ACCUM: on tree-output valid, acc += group sum, fold_cnt++; when fold_cnt reaches N, emit and return to IDLE, fold_cnt = 0.
  - No tree-output valid: hold state.
- Emit: o_data_bus <= final acc, o_valid <= 1 for exactly one cycle. o_data_bus holds last emitted value until next emit.
- i_num_folds is carried down the tree with the first beat; changes during ACCUM are ignored until the next sequence.
- No backpressure; every valid beat is accepted.
- o_busy = state==ACCUM or any tree-level valid bit set.

## Timing
- Reset (rst low, asynchronous): all tree valids 0, state IDLE, fold_cnt 0, acc 0, o_valid 0, o_data_bus 0, o_busy 0. In-flight beats are discarded. Tree data registers also reset to 0.
- Latency: beat sampled at edge e0 → group sum at tree output after edge e_LOG2G → o_valid/o_data_bus registered at edge e_(LOG2G+1). Default GROUP=8: 4 cycles from last beat to o_valid.
- Throughput: one beat per cycle sustained; back-to-back sequences with N=1 produce o_valid every cycle.
- Gaps (i_valid low) between beats of a sequence are allowed and only delay the emit.
- Final beat of sequence A and first beat of B on consecutive cycles: A emits, B starts the next cycle with no lost beat.

## Configuration
- REDUCE_ACCUM_SAT_EN defined: accumulator add (ACCUM state only) saturates to signed max/min of ACC_DATA_TYPE on overflow. Saturated value persists through further adds unless brought back in range by them. Tree adds still wrap.
- Not defined: accumulator wraps modulo 2^ACC_DATA_TYPE.

## Test plan
- Reset mid-sequence: N=4, 2 beats sent, assert rst → o_valid 0, o_data_bus 0, o_busy 0; fresh N=1 beat then yields a correct result 4 cycles later.
- N=1, all lanes = 1, default params → single o_valid 4 cycles after beat, every group = 8.
- N=3, lanes = 2, -1, 5 on three beats with a 2-cycle gap → one o_valid, every group = 48; no o_valid earlier.
- Back-to-back N=1 beats with lanes 1,2,3 on consecutive cycles → o_valid on three consecutive cycles, groups 8, 16, 24.
- i_num_folds changed from 2 to 5 between beats of a sequence → output after 2 beats; i_num_folds = 0 → behaves as N=1.
- Overflow: ACC_DATA_TYPE=28, lanes = 2^23-1, N=8 → wrapped sum without macro; 2^27-1 with REDUCE_ACCUM_SAT_EN.
